// File: rtl/mem_arbiter_pkg.sv
// Shared types and limits for the two-port system RAM arbiter.
package mem_arbiter_pkg;

   localparam int unsigned WORD_W             = 8;
   localparam int unsigned ARB_MAX_BURST_W    = 4;
   localparam int unsigned ARB_MAX_RD_LATENCY = 4;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_OWN0,
      ARB_OWN1
   } e_arb_state;

   typedef struct packed {
      logic valid;
      logic port;
   } arb_tag_t;

endpackage

// File: rtl/mem_arbiter_rd_pipe.sv
// Fixed-depth shift pipe tracking outstanding read owners; flushed by reset.
module mem_arbiter_rd_pipe
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic     clk,
   input  logic     rst,
   input  arb_tag_t push,
   output arb_tag_t tail
);

   arb_tag_t stage_q [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= push;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tail = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one RAM port between CPU (port 0) and loader (port 1).
// Optional MMIO output register enabled by MEM_ARBITER_MMIO_EN.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned MAX_BURST  = 4,
   parameter word_t       MMIO_ADDR  = 8'hFF
) (
   input  logic  clk,
   input  logic  rst,
`ifdef MEM_ARBITER_MMIO_EN
   output word_t mmio_out,
`endif
   input  logic  req0,
   input  logic  we0,
   input  word_t addr0,
   input  word_t wdata0,
   output logic  gnt0,
   output logic  rvalid0,
   output word_t rdata0,
   input  logic  req1,
   input  logic  we1,
   input  word_t addr1,
   input  word_t wdata1,
   output logic  gnt1,
   output logic  rvalid1,
   output word_t rdata1,
   output logic  mem_wr_en,
   output word_t mem_addr,
   output word_t mem_wr_data,
   input  word_t mem_rd_data
);

   localparam int unsigned LAT = (RD_LATENCY < 1) ? 1 :
                                 (RD_LATENCY > ARB_MAX_RD_LATENCY) ? ARB_MAX_RD_LATENCY : RD_LATENCY;
   localparam logic [ARB_MAX_BURST_W-1:0] MAX_B     = ARB_MAX_BURST_W'(MAX_BURST);
   localparam logic [ARB_MAX_BURST_W-1:0] BURST_ONE = ARB_MAX_BURST_W'(1);

   e_arb_state                 state_q, state_d;
   logic [ARB_MAX_BURST_W-1:0] burst_q, burst_d;
   logic                       last_q, last_d;
   word_t                      addr_q, wdata_q, rdata0_q, rdata1_q;

   logic     sel_valid, sel_port, gnt_any, sel_we, mmio_hit_c;
   word_t    sel_addr, sel_wdata, rd_src;
   arb_tag_t push_tag, ret_tag;

   // Grant selection: single requester wins; ties rotate, bounded by the burst limit.
   always_comb begin
      sel_valid = 1'b0;
      sel_port  = 1'b0;
      if (req0 && req1) begin
         sel_valid = 1'b1;
         case (state_q)
            ARB_OWN0: sel_port = (burst_q < MAX_B) ? 1'b0 : 1'b1;
            ARB_OWN1: sel_port = (burst_q < MAX_B) ? 1'b1 : 1'b0;
            default:  sel_port = ~last_q;
         endcase
      end else if (req0) begin
         sel_valid = 1'b1;
      end else if (req1) begin
         sel_valid = 1'b1;
         sel_port  = 1'b1;
      end
   end

   assign gnt_any   = rst & sel_valid;
   assign gnt0      = gnt_any & ~sel_port;
   assign gnt1      = gnt_any & sel_port;
   assign sel_we    = sel_port ? we1    : we0;
   assign sel_addr  = sel_port ? addr1  : addr0;
   assign sel_wdata = sel_port ? wdata1 : wdata0;

`ifdef MEM_ARBITER_MMIO_EN
   assign mmio_hit_c = (sel_addr == MMIO_ADDR);
`else
   assign mmio_hit_c = 1'b0;
`endif

   assign mem_wr_en   = gnt_any & sel_we & ~mmio_hit_c;
   assign mem_addr    = gnt_any ? sel_addr  : addr_q;
   assign mem_wr_data = gnt_any ? sel_wdata : wdata_q;

   // Ownership and burst tracking for the next cycle.
   always_comb begin
      state_d = ARB_IDLE;
      burst_d = '0;
      last_d  = last_q;
      if (gnt_any) begin
         last_d  = sel_port;
         state_d = sel_port ? ARB_OWN1 : ARB_OWN0;
         if (state_q == state_d) burst_d = (burst_q == '1) ? burst_q : burst_q + BURST_ONE;
         else                    burst_d = BURST_ONE;
      end
   end

   assign push_tag = '{valid: gnt_any & ~sel_we, port: sel_port};

   mem_arbiter_rd_pipe #(.DEPTH(LAT)) u_rd_pipe (
      .clk  (clk),
      .rst  (rst),
      .push (push_tag),
      .tail (ret_tag)
   );

`ifdef MEM_ARBITER_MMIO_EN
   word_t       mmio_q;
   logic [LAT-1:0] mm_hit_q;
   word_t       mm_snap_q [LAT];

   // MMIO reads ride alongside the tag pipe with the register value captured at issue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mmio_q   <= '0;
         mm_hit_q <= '0;
         for (int i = 0; i < LAT; i++) mm_snap_q[i] <= '0;
      end else begin
         if (gnt_any && sel_we && mmio_hit_c) mmio_q <= sel_wdata;
         mm_hit_q[0]  <= gnt_any & ~sel_we & mmio_hit_c;
         mm_snap_q[0] <= mmio_q;
         for (int i = 1; i < LAT; i++) begin
            mm_hit_q[i]  <= mm_hit_q[i-1];
            mm_snap_q[i] <= mm_snap_q[i-1];
         end
      end
   end

   assign mmio_out = mmio_q;
   assign rd_src   = mm_hit_q[LAT-1] ? mm_snap_q[LAT-1] : mem_rd_data;
`else
   assign rd_src   = mem_rd_data;
`endif

   assign rvalid0 = ret_tag.valid & ~ret_tag.port;
   assign rvalid1 = ret_tag.valid & ret_tag.port;
   assign rdata0  = rvalid0 ? rd_src : rdata0_q;
   assign rdata1  = rvalid1 ? rd_src : rdata1_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ARB_IDLE;
         burst_q  <= '0;
         last_q   <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q <= state_d;
         burst_q <= burst_d;
         last_q  <= last_d;
         if (gnt_any) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
         if (rvalid0) rdata0_q <= rd_src;
         if (rvalid1) rdata1_q <= rd_src;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized two-port traffic vs a queue model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int unsigned LAT    = 2;
   localparam int unsigned MAXB   = 4;
   localparam logic [7:0]  MMIO_A = 8'hFF;

   logic clk = 1'b0;
   logic rst;
   logic req0, we0, gnt0, rvalid0, req1, we1, gnt1, rvalid1, mem_wr_en;
   logic [7:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
   logic [7:0] mem_addr, mem_wr_data, mem_rd_data;
`ifdef MEM_ARBITER_MMIO_EN
   logic [7:0] mmio_out;
`endif

   always #5 clk = ~clk;

   mem_arbiter #(.RD_LATENCY(LAT), .MAX_BURST(MAXB), .MMIO_ADDR(MMIO_A)) dut (
      .clk(clk), .rst(rst),
`ifdef MEM_ARBITER_MMIO_EN
      .mmio_out(mmio_out),
`endif
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_data(mem_rd_data)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] init_val(input int a);
      if (a == 16) return 8'hA5;
      return 8'((a * 37 + 11) & 255);
   endfunction

   // RAM environment: read data appears LAT cycles after the address is issued.
   logic [7:0] ram [256];
   logic [7:0] rd_pipe [LAT];
   assign mem_rd_data = rd_pipe[LAT-1];

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = init_val(i);
      forever begin
         @(posedge clk);
         rd_pipe[0] <= ram[mem_addr];
         for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
      end
   end

   // Reference model: arbitration by run length, read returns scheduled by absolute cycle.
   typedef struct { int cyc; bit port; logic [7:0] data; } ret_t;
   ret_t       rq [$];
   logic [7:0] mram [256];
   int         m_prev, m_run, m_last, cyc;
   logic [7:0] m_rd0, m_rd1, m_mmio, m_addr, m_wdata;

   initial begin
      int sel;
      logic s_we;
      logic [7:0] s_addr, s_wd;
      bit hit, erv0, erv1;
      ret_t r;
      for (int i = 0; i < 256; i++) mram[i] = init_val(i);
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("rst_gnt", {gnt1, gnt0}, 0);
            chk("rst_rvalid", {rvalid1, rvalid0}, 0);
            chk("rst_rdata", {rdata1, rdata0}, 0);
            chk("rst_mem", {mem_wr_en, mem_addr, mem_wr_data}, 0);
`ifdef MEM_ARBITER_MMIO_EN
            chk("rst_mmio", mmio_out, 0);
`endif
            m_prev = -1; m_run = 0; m_last = 1;
            m_rd0 = 0; m_rd1 = 0; m_mmio = 0; m_addr = 0; m_wdata = 0;
            rq.delete();
         end else begin
            sel = -1;
            if (req0 && req1) begin
               if (m_prev < 0)               sel = 1 - m_last;
               else if (m_run < int'(MAXB))  sel = m_prev;
               else                          sel = 1 - m_prev;
            end else if (req0) sel = 0;
            else if (req1)     sel = 1;
            chk("gnt0", gnt0, (sel == 0));
            chk("gnt1", gnt1, (sel == 1));
`ifdef MEM_ARBITER_MMIO_EN
            chk("mmio_out", mmio_out, m_mmio);
`endif
            s_we = 0; hit = 0;
            if (sel >= 0) begin
               s_we   = (sel == 1) ? we1 : we0;
               s_addr = (sel == 1) ? addr1 : addr0;
               s_wd   = (sel == 1) ? wdata1 : wdata0;
`ifdef MEM_ARBITER_MMIO_EN
               hit = (s_addr == MMIO_A);
`endif
               m_addr = s_addr; m_wdata = s_wd;
            end
            chk("mem_wr_en", mem_wr_en, (sel >= 0) && s_we && !hit);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wr_data", mem_wr_data, m_wdata);
            erv0 = 0; erv1 = 0;
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
               r = rq.pop_front();
               if (r.port) begin erv1 = 1; m_rd1 = r.data; end
               else        begin erv0 = 1; m_rd0 = r.data; end
            end
            chk("rvalid0", rvalid0, erv0);
            chk("rvalid1", rvalid1, erv1);
            chk("rdata0", rdata0, m_rd0);
            chk("rdata1", rdata1, m_rd1);
            if (sel >= 0) begin
               if (sel == m_prev) m_run = (m_run < 15) ? m_run + 1 : 15;
               else               m_run = 1;
               m_prev = sel; m_last = sel;
               if (s_we) begin
                  if (hit) m_mmio = s_wd;
                  else     mram[s_addr] = s_wd;
               end else begin
                  rq.push_back('{cyc + int'(LAT), bit'(sel), hit ? m_mmio : mram[s_addr]});
               end
            end else begin
               m_prev = -1; m_run = 0;
            end
         end
         cyc++;
      end
   end

   task automatic idle_all();
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 0; idle_all();
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1;
   endtask

   task automatic upd(input logic g, input bit allow, input int prob, inout bit pend,
                      output logic req, inout logic we, inout logic [7:0] addr, inout logic [7:0] wdata);
      if (pend && g) pend = 0;
      if (pend && (!allow || $urandom_range(0, 19) == 0)) pend = 0;
      if (!pend && allow && int'($urandom_range(0, 9)) < prob) begin
         pend  = 1;
         we    = 1'($urandom_range(0, 1));
         addr  = ($urandom_range(0, 7) == 0) ? MMIO_A : 8'($urandom_range(0, 31));
         wdata = 8'($urandom);
      end
      req = pend;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      int seq [12];
      int exp_seq [12];
      bit pend0, pend1;
      logic g0, g1;
      exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
      rst = 0; idle_all();
      repeat (2) @(negedge clk);
      chk("reset_state", {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, rdata0, rdata1, mem_addr}, 0);
      @(posedge clk); #1;
      rst = 1;

      // Single read at 0x10 (RAM holds 0xA5).
      req0 = 1; addr0 = 8'h10;
      @(negedge clk);
      chk("t1_gnt", {gnt0, gnt1}, 2'b10);
      @(posedge clk); #1 idle_all();
      repeat (LAT - 1) @(negedge clk);
      chk("t1_early", {rvalid0, rvalid1}, 0);
      @(negedge clk);
      chk("t1_rvalid", {rvalid0, rvalid1}, 2'b10);
      chk("t1_rdata", rdata0, 8'hA5);

      // Both requesting: bursts of MAX_BURST alternate.
      do_reset();
      req0 = 1; addr0 = 8'h01; req1 = 1; addr1 = 8'h02;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("t2_onehot", gnt0 & gnt1, 0);
         seq[i] = gnt1 ? 1 : (gnt0 ? 0 : 9);
      end
      for (int i = 0; i < 12; i++) chk("t2_burst_seq", seq[i], exp_seq[i]);
      @(posedge clk); #1 idle_all();
      repeat (LAT + 2) @(negedge clk);

      // Port 1 write then port 0 read of the same location.
      @(posedge clk); #1;
      req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3C;
      @(negedge clk);
      chk("t3_wr", {gnt1, mem_wr_en, mem_addr, mem_wr_data}, {2'b11, 8'h20, 8'h3C});
      @(posedge clk); #1;
      idle_all(); req0 = 1; addr0 = 8'h20;
      @(negedge clk);
      chk("t3_rd_gnt", gnt0, 1);
      @(posedge clk); #1 idle_all();
      repeat (LAT - 1) begin @(negedge clk); chk("t3_no_rv1", rvalid1, 0); end
      @(negedge clk);
      chk("t3_rv", {rvalid0, rvalid1}, 2'b10);
      chk("t3_rdata", rdata0, 8'h3C);

      // Back-to-back port 1 reads 0..7.
      @(posedge clk); #1;
      for (int k = 0; k < 8 + int'(LAT) + 1; k++) begin
         if (k < 8) begin req1 = 1; addr1 = 8'(k); end
         else       idle_all();
         @(negedge clk);
         if (k < 8) chk("t4_gnt1", gnt1, 1);
         chk("t4_rvalid1", rvalid1, (k >= int'(LAT)) && (k < 8 + int'(LAT)));
         if (k >= int'(LAT) && k < 8 + int'(LAT)) chk("t4_rdata1", rdata1, init_val(k - int'(LAT)));
         @(posedge clk); #1;
      end

      // Reset while two reads are in flight.
      req0 = 1; addr0 = 8'h03;
      @(negedge clk);
      @(posedge clk); #1 addr0 = 8'h04;
      @(negedge clk);
      @(posedge clk); #1 addr0 = 8'h05;
      #2 rst = 0;
      #1 chk("t5_async", {gnt0, gnt1, rvalid0, rvalid1, mem_wr_en, mem_addr, mem_wr_data, rdata0, rdata1}, 0);
      idle_all();
      @(posedge clk); #1 rst = 1;
      for (int k = 0; k < int'(LAT) + 3; k++) begin
         @(negedge clk);
         chk("t5_no_rv", {rvalid0, rvalid1}, 0);
      end

      // Randomized traffic, with a port-0-only window to saturate the burst counter.
      pend0 = 0; pend1 = 0;
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk); g0 = gnt0; g1 = gnt1;
         @(posedge clk); #1;
         upd(g0, 1'b1, (n >= 700 && n < 800) ? 10 : 6, pend0, req0, we0, addr0, wdata0);
         upd(g1, !(n >= 700 && n < 800), 6, pend1, req1, we1, addr1, wdata1);
      end
      idle_all();
      repeat (LAT + 2) @(negedge clk);

`ifdef MEM_ARBITER_MMIO_EN
      do_reset();
      @(negedge clk);
      chk("t6_mmio_rst", mmio_out, 0);
      @(posedge clk); #1;
      req0 = 1; we0 = 1; addr0 = MMIO_A; wdata0 = 8'h42;
      @(negedge clk);
      chk("t6_wr", {gnt0, mem_wr_en}, 2'b10);
      @(posedge clk); #1 we0 = 0;
      @(negedge clk);
      chk("t6_mmio", mmio_out, 8'h42);
      @(posedge clk); #1 idle_all();
      repeat (LAT - 1) @(negedge clk);
      @(negedge clk);
      chk("t6_rd", {rvalid0, rdata0}, {1'b1, 8'h42});
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
